// File: rtl/cram_arb_pkg.sv
// Shared definitions for the Cellular RAM port arbiter: client indices,
// FSM state encoding, STAT field positions and the fixed-priority picker.
package cram_arb_pkg;

  localparam int NCLIENT = 3;

  localparam logic [1:0] CL_DISP  = 2'd0;
  localparam logic [1:0] CL_CAPT  = 2'd1;
  localparam logic [1:0] CL_MCS   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  localparam int STAT_SEL_LSB   = 0;
  localparam int STAT_EN_LSB    = 2;
  localparam int STAT_ERR_BIT   = 5;
  localparam int STAT_ERRID_LSB = 6;

  // Lowest set index wins (display > capture > MCS); SEL_NONE when empty.
  function automatic logic [1:0] lowest_client(input logic [2:0] v);
    logic [1:0] r;
    r = SEL_NONE;
    if (v[2]) r = CL_MCS;
    if (v[1]) r = CL_CAPT;
    if (v[0]) r = CL_DISP;
    return r;
  endfunction

endpackage

// File: rtl/cram_arb_waitcnt.sv
// One client's saturating wait counter and its urgency flag.
import cram_arb_pkg::*;

module cram_arb_waitcnt #(
  parameter int MAXWAIT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic elig,
  input  logic granted,
  output logic urgent
);

  logic [7:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (!elig || granted) begin
      cnt <= '0;
    end else if (cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign urgent = elig && (cnt >= 8'(MAXWAIT));

endmodule

// File: rtl/cram_arbiter.sv
// Request/grant arbiter for the single Cellular RAM port: one-hot grant,
// encoded pin-mux select, turnaround gaps, starvation promotion, hold watchdog.
import cram_arb_pkg::*;

module cram_arbiter #(
  parameter int TURN     = 2,
  parameter int MAXWAIT  = 64,
  parameter int HOLD_MAX = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  REQ,
  input  logic [2:0]  LAST,
  output logic [2:0]  GNT,
  output logic [1:0]  SEL,
  output logic        BUSY,
  input  logic        CFG_WE,
  input  logic [3:0]  CFG_DIN,
  output logic [31:0] STAT
);

  localparam logic [15:0] HOLD_LIM = 16'(HOLD_MAX - 1);
  localparam logic [3:0]  TURN_LD  = 4'(TURN - 1);

  // Handshake: a client holds REQ until GNT; the owner keeps GNT until it
  // pulses LAST (or the watchdog revokes); REQ/LAST of non-owners are ignored.

  arb_state_t  state, state_n;
  logic [2:0]  gnt_q, gnt_n;
  logic [1:0]  sel_q, sel_n;
  logic [15:0] hold_q, hold_n;
  logic [3:0]  turn_q, turn_n;
  logic [2:0]  en_q;
  logic        err_q;
  logic [1:0]  err_id_q;

  logic [2:0]  elig, urgent, urg_elig;
  logic [1:0]  pick;
  logic        last_own, wd_fire;

  assign elig = REQ & en_q;

  for (genvar i = 0; i < NCLIENT; i++) begin : g_wait
    cram_arb_waitcnt #(.MAXWAIT(MAXWAIT)) u_wait (
      .CLK     (CLK),
      .RST     (RST),
      .elig    (elig[i]),
      .granted (gnt_q[i]),
      .urgent  (urgent[i])
    );
  end

  always_comb begin
    urg_elig = elig & urgent;
    pick     = (urg_elig != 3'b000) ? lowest_client(urg_elig) : lowest_client(elig);
    last_own = |(LAST & gnt_q);
    wd_fire  = (state == ST_GRANT) && !last_own && (hold_q == HOLD_LIM);

    state_n = state;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    hold_n  = hold_q;
    turn_n  = turn_q;

    case (state)
      ST_IDLE: begin
        if (elig != 3'b000) begin
          state_n = ST_GRANT;
          gnt_n   = 3'b001 << pick;
          sel_n   = pick;
          hold_n  = '0;
        end
      end
      ST_GRANT: begin
        if (last_own || wd_fire) begin
          state_n = ST_TURN;
          gnt_n   = '0;
          sel_n   = SEL_NONE;
          turn_n  = TURN_LD;
        end else begin
          hold_n = hold_q + 16'd1;
        end
      end
      ST_TURN: begin
        if (turn_q == 4'd0) state_n = ST_IDLE;
        else                turn_n  = turn_q - 4'd1;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        sel_n   = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      sel_q  <= SEL_NONE;
      hold_q <= '0;
      turn_q <= '0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      sel_q  <= sel_n;
      hold_q <= hold_n;
      turn_q <= turn_n;
    end
  end

  // A watchdog hit in the same cycle as an error-clear write keeps ERR set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q     <= 3'b111;
      err_q    <= 1'b0;
      err_id_q <= 2'd0;
    end else begin
      if (CFG_WE) en_q <= CFG_DIN[2:0];
      if (wd_fire) begin
        err_q    <= 1'b1;
        err_id_q <= sel_q;
      end else if (CFG_WE && CFG_DIN[3]) begin
        err_q    <= 1'b0;
        err_id_q <= 2'd0;
      end
    end
  end

  always_comb begin
    STAT = '0;
    STAT[STAT_SEL_LSB +: 2]   = sel_q;
    STAT[STAT_EN_LSB +: 3]    = en_q;
    STAT[STAT_ERR_BIT]        = err_q;
    STAT[STAT_ERRID_LSB +: 2] = err_id_q;
  end

  assign GNT  = gnt_q;
  assign SEL  = sel_q;
  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_cram_arbiter.sv
// Scoreboard bench for cram_arbiter: a transaction-level reference model
// predicts GNT/SEL/BUSY/STAT each cycle; a monitor compares them.
module tb_cram_arbiter;

  localparam int TURN     = 2;
  localparam int MAXWAIT  = 64;
  localparam int HOLD_MAX = 1024;
  localparam int W        = 38;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  REQ = '0;
  logic [2:0]  LAST = '0;
  logic [2:0]  GNT;
  logic [1:0]  SEL;
  logic        BUSY;
  logic        CFG_WE = 1'b0;
  logic [3:0]  CFG_DIN = '0;
  logic [31:0] STAT;

  always #5 CLK = ~CLK;

  cram_arbiter #(.TURN(TURN), .MAXWAIT(MAXWAIT), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LAST(LAST), .GNT(GNT), .SEL(SEL),
    .BUSY(BUSY), .CFG_WE(CFG_WE), .CFG_DIN(CFG_DIN), .STAT(STAT)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: who owns the port, how many grant cycles elapsed,
  // how many turnaround cycles remain, and how long each client has waited.
  int         m_owner = -1;
  int         m_held  = 0;
  int         m_gap   = 0;
  int         m_wait[3];
  logic [2:0] m_en    = 3'b111;
  logic       m_err   = 1'b0;
  logic [1:0] m_err_id = 2'd0;

  always @(posedge CLK) begin
    logic [2:0]  e, u, pool;
    int          win, prev;
    logic [2:0]  g;
    logic [1:0]  s;
    logic [31:0] st;
    if (RST) begin
      m_owner = -1; m_held = 0; m_gap = 0;
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
      m_en = 3'b111; m_err = 1'b0; m_err_id = 2'd0;
    end else begin
      e = REQ & m_en;
      u = '0;
      for (int i = 0; i < 3; i++) if (e[i] && m_wait[i] >= MAXWAIT) u[i] = 1'b1;
      pool = (u != 0) ? u : e;
      win = -1;
      for (int i = 2; i >= 0; i--) if (pool[i]) win = i;
      for (int i = 0; i < 3; i++)
        if (e[i] && m_owner != i) m_wait[i] = (m_wait[i] < 255) ? m_wait[i] + 1 : 255;
        else                      m_wait[i] = 0;
      if (CFG_WE) begin
        m_en = CFG_DIN[2:0];
        if (CFG_DIN[3]) begin m_err = 1'b0; m_err_id = 2'd0; end
      end
      prev = m_owner;
      if (m_owner >= 0) begin
        if (LAST[m_owner]) begin
          m_owner = -1; m_gap = TURN;
        end else if (m_held == HOLD_MAX) begin
          m_owner = -1; m_gap = TURN;
          m_err = 1'b1; m_err_id = 2'(prev);
        end else begin
          m_held++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (win >= 0) begin
        m_owner = win; m_held = 1;
      end
    end
    g  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    s  = (m_owner >= 0) ? 2'(m_owner) : 2'd3;
    st = {24'b0, m_err_id, m_err, m_en, s};
    exp_q.push_back({g, s, (m_owner >= 0 || m_gap > 0), st});
  end

  always @(negedge CLK) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {GNT, SEL, BUSY, STAT};
      checks++;
      if (act_v === exp_v) passed++;
      else $display("FAIL scoreboard t=%0t gnt %b exp %b sel %0d exp %0d busy %b exp %b stat %h exp %h",
                    $time, act_v[37:35], exp_v[37:35], act_v[34:33], exp_v[34:33],
                    act_v[32], exp_v[32], act_v[31:0], exp_v[31:0]);
    end
  end

  // Client driver state: requesting clients, burst length (0 = never LAST),
  // remaining transactions.
  logic [2:0] want = '0;
  int         burst[3];
  int         reps[3];

  task automatic tick(input logic rst_i, input logic we_i, input logic [3:0] din_i,
                      input logic noise);
    logic [2:0] l, own_mask;
    @(negedge CLK);
    l = '0;
    own_mask = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    for (int i = 0; i < 3; i++)
      if (m_owner == i && burst[i] != 0 && m_held >= burst[i]) begin
        l[i] = 1'b1;
        if (reps[i] > 0) reps[i]--;
        if (reps[i] == 0) want[i] = 1'b0;
      end
    if (noise) l = l | (3'($urandom_range(0, 7)) & ~own_mask);
    RST = rst_i; REQ = want; LAST = l; CFG_WE = we_i; CFG_DIN = din_i;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic client(input int i, input int b, input int r);
    want[i] = 1'b1; burst[i] = b; reps[i] = r;
  endtask

  task automatic bound_check(input logic ok, input string name);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s bound expired owner %0d held %0d", name, m_owner, m_held);
  endtask

  logic       r_we, r_rst;
  logic [3:0] r_din;

  initial begin
    for (int i = 0; i < 3; i++) begin burst[i] = 1; reps[i] = 0; end
    tick(1'b1, 1'b0, 4'b0000, 1'b0);
    tick(1'b1, 1'b0, 4'b0000, 1'b0);
    idle(3);

    // MCS alone, five-cycle transaction
    client(2, 5, 1);
    idle(15);

    // All three at once: display, capture, MCS in order with turnaround gaps
    client(0, 4, 1); client(1, 4, 1); client(2, 4, 1);
    idle(40);

    // Display streams 50-cycle bursts; MCS must get promoted
    client(0, 50, 3); client(2, 3, 1);
    idle(260);
    want = '0;
    idle(10);

    // Capture never ends its transaction: watchdog revoke and sticky error
    client(1, 0, 1);
    for (int n = 0; n < 1200 && !m_err; n++) idle(1);
    bound_check(m_err, "watchdog_fire");
    want[1] = 1'b0;
    idle(5);
    tick(1'b0, 1'b1, 4'b1111, 1'b0);
    idle(5);

    // Watchdog and error clear landing on the same edge: set wins
    client(1, 0, 1);
    for (int n = 0; n < 1200 && !(m_owner == 1 && m_held == HOLD_MAX - 1); n++) idle(1);
    bound_check(m_owner == 1 && m_held == HOLD_MAX - 1, "watchdog_near");
    want[1] = 1'b0;
    tick(1'b0, 1'b1, 4'b1111, 1'b0);
    idle(5);
    tick(1'b0, 1'b1, 4'b1111, 1'b0);
    idle(3);

    // MCS masked off while requesting, then re-enabled
    tick(1'b0, 1'b1, 4'b0011, 1'b0);
    client(2, 3, 1);
    idle(100);
    tick(1'b0, 1'b1, 4'b0111, 1'b0);
    idle(10);

    // Reset in the third cycle of a display grant, then normal service
    client(0, 20, 1);
    for (int n = 0; n < 50 && !(m_owner == 0 && m_held == 2); n++) idle(1);
    bound_check(m_owner == 0 && m_held == 2, "reset_mid_grant");
    tick(1'b1, 1'b0, 4'b0000, 1'b0);
    idle(40);

    // Random traffic with spurious LAST, mask writes and occasional reset
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++)
        if (!want[i] && $urandom_range(0, 7) == 0)
          client(i, $urandom_range(1, 8), $urandom_range(1, 3));
      r_we  = ($urandom_range(0, 39) == 0);
      r_din = {1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111};
      r_rst = ($urandom_range(0, 299) == 0);
      tick(r_rst, r_we, r_din, 1'b1);
    end
    want = '0;
    tick(1'b0, 1'b1, 4'b1111, 1'b0);
    idle(30);

    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL queue_drain pending %0d required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cram_arbiter.md
Name: cram_arbiter

Overview:
- Dynamic arbiter for the single Cellular RAM port. It replaces static mode selection with request/grant sharing between three clients: display fetch, capture write and MCS CPU access.
- Issues a one-hot grant and an encoded select that drives the memory pin mux.
- Enforces bus turnaround gaps, starvation promotion and a grant-hold watchdog.
- Sits between the client engines and the memory pin multiplexer; it is configured and monitored over the I/O bus.

Parameters:
- TURN, 2: idle cycles inserted after each grant ends (bus turnaround); range 1..15.
- MAXWAIT, 64: wait cycles after which a requester becomes urgent; range 1..255.
- HOLD_MAX, 1024: maximum cycles a grant may be held without LAST; range 2..65535.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- REQ  in  3  request per client; bit0 display, bit1 capture, bit2 MCS
- LAST  in  3  per-client final-cycle strobe of the current transaction
- GNT  out  3  one-hot registered grant
- SEL  out  2  encoded owner: 0 display, 1 capture, 2 MCS, 3 none
- BUSY  out  1  high while in GRANT or TURN
- CFG_WE  in  1  configuration write strobe
- CFG_DIN  in  4  [2:0] enable mask, [3] error clear (write-1)
- STAT  out  32  {24'b0, ERR_ID[1:0], ERR, EN[2:0], SEL[1:0]}

Behaviour:
- Reset values: GNT=0, SEL=3, BUSY=0, EN=3'b111, ERR=0, ERR_ID=0, all counters 0, state IDLE. Reset mid-grant drops GNT at that edge; the client must abort.
- Eligible set: E = REQ & EN. Urgent set: U = clients in E whose wait counter is ≥ MAXWAIT.
- Winner selection: if U is non-zero, the lowest index in U wins; otherwise the lowest index in E wins (display > capture > MCS).
- IDLE: if E is non-zero at edge k, then GNT, SEL and BUSY are set after edge k; state becomes GRANT; hold counter is cleared. Latency is one cycle from sampled REQ to GNT.
- GRANT:
  - LAST of the granted client high at edge k: GNT=0 and SEL=3 after edge k; go to TURN with turn counter loaded to TURN-1.
  - LAST in the first grant cycle is legal (single-cycle transaction).
  - LAST or REQ edges from non-granted clients are ignored.
  - Dropping REQ while granted has no effect; only LAST ends the grant.
- Watchdog: the hold counter increments every GRANT cycle. When it reaches HOLD_MAX-1 without LAST, the grant is revoked as for LAST. Additionally, ERR=1 and ERR_ID=the owner index. ERR is sticky.
- TURN: counter decrements each cycle. In the cycle the counter is 0, BUSY stays high and the next edge returns to IDLE. There are exactly TURN idle cycles between a grant falling and the next grant rising, plus the 1-cycle IDLE arbitration.
- Wait counters, per client, 8-bit saturating at 255:
  - +1 each cycle the client is in E and not granted.
  - Cleared when the client is granted or leaves E.
- Configuration write (CFG_WE): EN<=CFG_DIN[2:0]. ERR and ERR_ID clear when CFG_DIN[3]=1. If the watchdog fires in the same cycle, the set wins.
- Disabling the current owner's EN does not revoke its grant. The grant ends on LAST or the watchdog.
- With EN=0, GNT stays 0 indefinitely and the wait counters hold at 0.

Decomposition:
- Package cram_arb_pkg holds:
  - client indices CL_DISP=0, CL_CAPT=1, CL_MCS=2 and SEL_NONE=3;
  - state encoding IDLE/GRANT/TURN;
  - STAT bit positions.
- Sub-module cram_arb_waitcnt: one client's saturating wait counter plus urgent compare against MAXWAIT; instantiated three times.

Test Plan:
- Only REQ=3'b100 at edge 0 -> GNT=3'b100 and SEL=2 after edge 0; LAST[2] at edge 5 -> GNT=0 after edge 5; BUSY low after edge 7 (TURN=2).
- Simultaneous REQ=3'b111 -> display is granted first. After display's LAST, the next grant goes to capture and then to MCS; gaps are each 3 cycles (2 TURN + 1 IDLE).
- Display re-requests continuously with 50-cycle bursts while MCS waits -> MCS becomes urgent once its wait counter reaches 64. MCS is granted at the next arbitration, ahead of display.
- Capture is granted and never asserts LAST -> GNT drops after 1024 grant cycles; STAT shows ERR=1 and ERR_ID=1. CFG_WE with CFG_DIN=4'b1111 -> ERR=0.
- EN=3'b011 written while REQ=3'b100 -> no grant for 100 cycles. EN=3'b111 written -> GNT=3'b100 one cycle later.
- RST asserted in the third cycle of a display grant -> GNT=0, SEL=3, STAT=32'h1F after the edge, and arbitration resumes normally.
